pipe_id: RTL

Instruction-decode front stage of the dynamic MIPS pipeline: the receiving end of the fetch-to-decode valid/allowin handshake. It latches the fetched PC and instruction, detects load-use hazards against the execute stage, and resolves branches, jumps, `jr`/`jalr` and `eret`. From that decode it drives the next-PC select and the 26-bit immediate back to the fetch stage. It also tracks branch-delay-slot status for CP0 and presents a valid/allowin handshake toward the execute stage.

---
 rtl/pipe_id_if.sv | 40 ++++
 rtl/pipe_id.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_id_if.sv
// Fetch/decode/execute handshake and operand bundle around the decode stage.
// slave  : the decode stage (pipe_id) view.
// master : the surrounding pipeline (fetch, execute, forwarding, CP0) view.
interface pipe_id_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REGW   = 5;
    localparam int unsigned SELW   = 3;
    localparam int unsigned IMMW   = 26;

    logic              if_id_validto;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_instr;
    logic              id_allowin;
    logic              ex_allowin;
    logic              id_ex_validto;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_instr;
    logic              id_bd;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic              ex_valid_load;
    logic [REGW-1:0]   ex_wreg;
    logic              exc_flush;
    logic [SELW-1:0]   pc_mux_sel;
    logic [IMMW-1:0]   imm_out;

    modport slave (
        input  if_id_validto, if_pc, if_instr, ex_allowin,
               rs_data, rt_data, ex_valid_load, ex_wreg, exc_flush,
        output id_allowin, id_ex_validto, id_pc, id_instr, id_bd,
               pc_mux_sel, imm_out
    );

    modport master (
        output if_id_validto, if_pc, if_instr, ex_allowin,
               rs_data, rt_data, ex_valid_load, ex_wreg, exc_flush,
        input  id_allowin, id_ex_validto, id_pc, id_instr, id_bd,
               pc_mux_sel, imm_out
    );
endinterface

// File: rtl/pipe_id.sv
// Instruction-decode front stage of the MIPS pipeline.
// Latches PC/instruction from fetch, stalls on load-use hazards, resolves
// branches/jumps/jr/jalr/eret into a next-PC select for fetch, and tracks
// branch-delay-slot status.
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous active-low reset
//   bus  - pipe_id_if.slave: fetch handshake, execute handshake, forwarded
//          operands, load-hazard info, flush, next-PC select and immediate
module pipe_id #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    pipe_id_if.slave     bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned SELW = 3;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [XLEN-1:0] ERET_INSTR = 32'h4200_0018;

    localparam logic [SELW-1:0] SEL_PC4  = 3'd0;
    localparam logic [SELW-1:0] SEL_BR   = 3'd1;
    localparam logic [SELW-1:0] SEL_JUMP = 3'd2;
    localparam logic [SELW-1:0] SEL_RS   = 3'd3;
    localparam logic [SELW-1:0] SEL_EPC  = 3'd4;

    logic            id_valid_q,   id_valid_d;
    logic [XLEN-1:0] id_pc_q,      id_pc_d;
    logic [XLEN-1:0] id_instr_q,   id_instr_d;
    logic            id_bd_q,      id_bd_d;
    logic            bd_pending_q, bd_pending_d;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [REGW-1:0] rs_field;
    logic [REGW-1:0] rt_field;
    logic            hazard;
    logic            id_ready_go;
    logic            id_allowin_c;
    logic            id_ex_validto_c;
    logic            is_ctl;
    logic            bd_owed;
    logic [SELW-1:0] pc_mux_sel_c;

    assign opcode   = id_instr_q[31:26];
    assign funct    = id_instr_q[5:0];
    assign rs_field = id_instr_q[25:21];
    assign rt_field = id_instr_q[20:16];

    // Conservative load-use check: both source fields compared for every opcode
    always_comb begin
        hazard = id_valid_q && bus.ex_valid_load && (bus.ex_wreg != '0)
                 && ((bus.ex_wreg == rs_field) || (bus.ex_wreg == rt_field));
        id_ready_go     = !hazard;
        id_allowin_c    = !id_valid_q || (id_ready_go && bus.ex_allowin);
        id_ex_validto_c = id_valid_q && id_ready_go && !bus.exc_flush;
    end

    // Branch/jump resolution; select only asserted while the instruction can go
    always_comb begin
        pc_mux_sel_c = SEL_PC4;
        is_ctl       = 1'b0;
        case (opcode)
            OP_BEQ: begin
                is_ctl = 1'b1;
                if (bus.rs_data == bus.rt_data) pc_mux_sel_c = SEL_BR;
            end
            OP_BNE: begin
                is_ctl = 1'b1;
                if (bus.rs_data != bus.rt_data) pc_mux_sel_c = SEL_BR;
            end
            OP_J, OP_JAL: begin
                is_ctl       = 1'b1;
                pc_mux_sel_c = SEL_JUMP;
            end
            OP_SPECIAL: begin
                if ((funct == FN_JR) || (funct == FN_JALR)) begin
                    is_ctl       = 1'b1;
                    pc_mux_sel_c = SEL_RS;
                end
            end
            default: ;
        endcase
        if (id_instr_q == ERET_INSTR) pc_mux_sel_c = SEL_EPC;
        if (!id_ex_validto_c)         pc_mux_sel_c = SEL_PC4;
    end

    // Stage register update; a control transfer leaving in the same cycle
    // the next instruction arrives marks that arrival as its delay slot.
    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_bd_d      = id_bd_q;
        bd_pending_d = bd_pending_q;
        bd_owed      = bd_pending_q || (id_ex_validto_c && bus.ex_allowin && is_ctl);
        if (bus.exc_flush) begin
            id_valid_d   = 1'b0;
            bd_pending_d = 1'b0;
        end else if (id_allowin_c) begin
            id_valid_d = bus.if_id_validto;
            if (bus.if_id_validto) begin
                id_pc_d      = bus.if_pc;
                id_instr_d   = bus.if_instr;
                id_bd_d      = bd_owed;
                bd_pending_d = 1'b0;
            end else begin
                bd_pending_d = bd_owed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            id_bd_q      <= 1'b0;
            bd_pending_q <= 1'b0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_bd_q      <= id_bd_d;
            bd_pending_q <= bd_pending_d;
        end
    end

    assign bus.id_allowin    = id_allowin_c;
    assign bus.id_ex_validto = id_ex_validto_c;
    assign bus.id_pc         = id_pc_q;
    assign bus.id_instr      = id_instr_q;
    assign bus.id_bd         = id_bd_q;
    assign bus.pc_mux_sel    = pc_mux_sel_c;
    assign bus.imm_out       = id_instr_q[25:0];
endmodule
